pwm_capture: RTL

- Measures the high and low durations of an incoming PWM waveform in clk cycles.
- Packs each complete period into a 64-bit word with the same layout the PWM generator consumes: high count in [31:0], low count in [63:32].
- Writes that word as 8 bytes into a byte-wide FIFO.
- This is the writer/measurement counterpart to the FIFO-fed PWM generator, used for loopback and external PWM capture.

---
 rtl/pwm_capture.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures high/low durations of a PWM input and streams each completed period
// to a byte-wide FIFO as a 64-bit word {low_cnt, high_cnt}, most significant byte first.
module pwm_capture #(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned PWM_DATAWIDTH  = 64,
    parameter int unsigned PWM_FIFO_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture_en,
    input  logic                      PWM_in,
    input  logic                      full,
    output logic                      write,
    output logic [PWM_FIFO_WIDTH-1:0] o_data,
    output logic                      overrun,
    input  logic                      clear_overrun
);

    localparam int unsigned HALF   = PWM_DATAWIDTH / 2;
    localparam int unsigned NBYTES = PWM_DATAWIDTH / PWM_FIFO_WIDTH;
    localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [IDXW-1:0]          IDX_LAST = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {StWaitRise, StMeasHigh, StMeasLow} meas_state_t;
    typedef enum logic       {StIdle, StSend} ser_state_t;

    logic                     sync1_q, sync_q, prev_q;
    logic                     rise, fall, post;
    meas_state_t              meas_state_q;
    ser_state_t               ser_state_q;
    logic [COUNTER_WIDTH-1:0] high_cnt_q, low_cnt_q;
    logic [PWM_DATAWIDTH-1:0] meas_word, word_q;
    logic [IDXW-1:0]          idx_q;

    function automatic logic [PWM_FIFO_WIDTH-1:0] byte_sel(input logic [PWM_DATAWIDTH-1:0] w,
                                                           input int unsigned i);
        logic [PWM_DATAWIDTH-1:0] sh;
        sh = w << (PWM_FIFO_WIDTH * i);
        return sh[PWM_DATAWIDTH-1 -: PWM_FIFO_WIDTH];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= PWM_in;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    assign rise      = sync_q & ~prev_q;
    assign fall      = ~sync_q & prev_q;
    assign post      = capture_en & (meas_state_q == StMeasLow) & rise;
    assign meas_word = {HALF'(low_cnt_q), HALF'(high_cnt_q)};

    // The edge cycle itself counts as the first cycle of the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_state_q <= StWaitRise;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
        end else if (!capture_en) begin
            meas_state_q <= StWaitRise;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
        end else begin
            case (meas_state_q)
                StWaitRise: begin
                    if (rise) begin
                        high_cnt_q   <= CNT_ONE;
                        meas_state_q <= StMeasHigh;
                    end
                end
                StMeasHigh: begin
                    if (fall) begin
                        low_cnt_q    <= CNT_ONE;
                        meas_state_q <= StMeasLow;
                    end else if (sync_q && high_cnt_q != CNT_MAX) begin
                        high_cnt_q <= high_cnt_q + CNT_ONE;
                    end
                end
                StMeasLow: begin
                    if (rise) begin
                        high_cnt_q   <= CNT_ONE;
                        meas_state_q <= StMeasHigh;
                    end else if (!sync_q && low_cnt_q != CNT_MAX) begin
                        low_cnt_q <= low_cnt_q + CNT_ONE;
                    end
                end
                default: meas_state_q <= StWaitRise;
            endcase
        end
    end

    assign write = (ser_state_q == StSend) & ~full;

    // o_data is loaded one byte ahead so it always shows the byte at idx_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_state_q <= StIdle;
            idx_q       <= '0;
            word_q      <= '0;
            o_data      <= '0;
            overrun     <= 1'b0;
        end else begin
            case (ser_state_q)
                StIdle: begin
                    if (post) begin
                        word_q      <= meas_word;
                        idx_q       <= '0;
                        o_data      <= byte_sel(meas_word, 0);
                        ser_state_q <= StSend;
                    end
                end
                StSend: begin
                    if (!full) begin
                        if (idx_q == IDX_LAST) begin
                            ser_state_q <= StIdle;
                        end else begin
                            idx_q  <= idx_q + IDXW'(1);
                            o_data <= byte_sel(word_q, int'(idx_q) + 1);
                        end
                    end
                end
                default: ser_state_q <= StIdle;
            endcase

            if (post && ser_state_q == StSend) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
